// File: rtl/serial_pe_unit.sv
// Serial dot-product processing element: one signed 16x16 multiply-accumulate per
// qualified cycle, with a registered result and a one-cycle completion pulse.
module serial_pe_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] neuron,
    input  logic [15:0] weight,
    input  logic [1:0]  ctl,
    input  logic        vld_i,
    output logic [31:0] result,
    output logic        vld_o
);

    typedef enum logic [1:0] {
        CTL_MID    = 2'b00,
        CTL_FIRST  = 2'b01,
        CTL_LAST   = 2'b10,
        CTL_SINGLE = 2'b11
    } ctl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic        vld_q, vld_d;

    logic [31:0] neuron_ext_s;
    logic [31:0] weight_ext_s;
    logic [31:0] prod_s;
    ctl_e        ctl_s;

    // Sign-extend both operands so the low 32 bits of the product are exact.
    assign neuron_ext_s = {{16{neuron[15]}}, neuron};
    assign weight_ext_s = {{16{weight[15]}}, weight};
    assign prod_s       = neuron_ext_s * weight_ext_s;
    assign ctl_s        = ctl_e'(ctl);

    // State, accumulator and completion pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic; a LAST element only completes a vector opened since reset.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        vld_d   = 1'b0;
        if (vld_i) begin
            case (ctl_s)
                CTL_FIRST: begin
                    acc_d   = prod_s;
                    state_d = ST_OPEN;
                end
                CTL_MID: begin
                    acc_d = acc_q + prod_s;
                end
                CTL_LAST: begin
                    acc_d   = acc_q + prod_s;
                    vld_d   = (state_q == ST_OPEN);
                    state_d = ST_IDLE;
                end
                CTL_SINGLE: begin
                    acc_d   = prod_s;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    acc_d   = acc_q;
                    state_d = state_q;
                end
            endcase
        end else begin
            acc_d   = acc_q;
            state_d = state_q;
        end
    end

    assign result = acc_q;
    assign vld_o  = vld_q;

endmodule

// File: tb/tb_serial_pe_unit.sv
// Self-checking bench for serial_pe_unit: directed and randomized dot products
// compared against sums computed here with plain integer arithmetic.
module tb_serial_pe_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] neuron;
    logic [15:0] weight;
    logic [1:0]  ctl;
    logic        vld_i;
    logic [31:0] result;
    logic        vld_o;

    int errors = 0;
    int checks = 0;

    serial_pe_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .result (result),
        .vld_o  (vld_o)
    );

    always #5 clk = ~clk;

    // Signed product as plain integer arithmetic (int wraps at 32 bits).
    function automatic int prod(input logic [15:0] n, input logic [15:0] w);
        int a;
        int b;
        a = int'($signed(n));
        b = int'($signed(w));
        return a * b;
    endfunction

    // Drive one qualified element from the negedge phase; returns at the next negedge.
    task automatic step(input logic [15:0] n, input logic [15:0] w, input logic [1:0] c);
        neuron = n;
        weight = w;
        ctl    = c;
        vld_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        neuron = 16'($urandom);
        weight = 16'($urandom);
        ctl    = 2'($urandom);
        vld_i  = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        vld_i  = 1'b0;
        neuron = 16'd0;
        weight = 16'd0;
        ctl    = 2'b00;
        #2;
        checks++;
        if (result !== 32'd0 || vld_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: result=%h vld_o=%b want 0/0", result, vld_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        checks++;
        if (result !== 32'd0 || vld_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: result=%h vld_o=%b want 0/0", result, vld_o);
        end
    endtask

    task automatic test_ones_128();
        logic [1:0] c;
        for (int i = 0; i < 128; i++) begin
            c = (i == 0) ? 2'b01 : ((i == 127) ? 2'b10 : 2'b00);
            step(16'd1, 16'd2, c);
            checks++;
            if (vld_o !== (i == 127)) begin
                errors++;
                $display("FAIL ones_vld elem %0d: vld_o=%b want %b", i, vld_o, (i == 127));
            end
        end
        checks++;
        if (result !== 32'd256) begin
            errors++;
            $display("FAIL ones_result: result=%0d want 256", result);
        end
        idle();
        checks++;
        if (vld_o !== 1'b0 || result !== 32'd256) begin
            errors++;
            $display("FAIL ones_hold: vld_o=%b result=%0d want 0/256", vld_o, result);
        end
    endtask

    task automatic test_signed();
        step(16'hFFFD, 16'd4, 2'b01);
        step(16'd7, 16'hFFFE, 2'b00);
        checks++;
        if (vld_o !== 1'b0 || result !== 32'hFFFFFFE6) begin
            errors++;
            $display("FAIL signed_mid: vld_o=%b result=%h want 0/ffffffe6", vld_o, result);
        end
        step(16'hFFFB, 16'hFFFB, 2'b10);
        checks++;
        if (vld_o !== 1'b1 || result !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL signed_last: vld_o=%b result=%h want 1/ffffffff", vld_o, result);
        end
    endtask

    task automatic test_back_to_back();
        int          expv;
        logic [15:0] n;
        logic [15:0] w;
        logic [1:0]  c;
        for (int v = 0; v < 4; v++) begin
            expv = 0;
            for (int i = 0; i < 128; i++) begin
                n = 16'($urandom);
                w = 16'($urandom);
                c = (i == 0) ? 2'b01 : ((i == 127) ? 2'b10 : 2'b00);
                expv += prod(n, w);
                step(n, w, c);
                if (i != 127 && vld_o !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_stray vec %0d elem %0d: vld_o=1 want 0", v, i);
                end
            end
            checks++;
            if (vld_o !== 1'b1 || result !== 32'(expv)) begin
                errors++;
                $display("FAIL b2b_vec %0d: vld_o=%b result=%h want 1/%h", v, vld_o, result, 32'(expv));
            end
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            checks++;
            if (vld_o !== 1'b0 || result !== 32'(expv)) begin
                errors++;
                $display("FAIL b2b_hold %0d: vld_o=%b result=%h want 0/%h", k, vld_o, result, 32'(expv));
            end
        end
    endtask

    task automatic test_single_wrap();
        step(16'h7FFF, 16'h7FFF, 2'b11);
        checks++;
        if (vld_o !== 1'b1 || result !== 32'h3FFF0001) begin
            errors++;
            $display("FAIL single: vld_o=%b result=%h want 1/3fff0001", vld_o, result);
        end
        idle();
        checks++;
        if (vld_o !== 1'b0 || result !== 32'h3FFF0001) begin
            errors++;
            $display("FAIL single_hold: vld_o=%b result=%h want 0/3fff0001", vld_o, result);
        end
        step(16'h8000, 16'h8000, 2'b01);
        step(16'h8000, 16'h8000, 2'b00);
        step(16'h8000, 16'h8000, 2'b10);
        checks++;
        if (vld_o !== 1'b1 || result !== 32'hC0000000) begin
            errors++;
            $display("FAIL wrap: vld_o=%b result=%h want 1/c0000000", vld_o, result);
        end
    endtask

    task automatic test_restart();
        step(16'd100, 16'd100, 2'b01);
        step(16'd50, 16'd3, 2'b00);
        step(16'd6, 16'd7, 2'b01);
        checks++;
        if (vld_o !== 1'b0 || result !== 32'd42) begin
            errors++;
            $display("FAIL restart_first: vld_o=%b result=%0d want 0/42", vld_o, result);
        end
        step(16'hFFFF, 16'd2, 2'b10);
        checks++;
        if (vld_o !== 1'b1 || result !== 32'd40) begin
            errors++;
            $display("FAIL restart_last: vld_o=%b result=%0d want 1/40", vld_o, result);
        end
    endtask

    task automatic test_reset_mid_vector();
        step(16'($urandom), 16'($urandom), 2'b01);
        step(16'($urandom), 16'($urandom), 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'd0 || vld_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: result=%h vld_o=%b want 0/0", result, vld_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(16'd3, 16'd5, 2'b00);
        step(16'd2, 16'd2, 2'b10);
        checks++;
        if (vld_o !== 1'b0 || result !== 32'd19) begin
            errors++;
            $display("FAIL midreset_nostray: vld_o=%b result=%0d want 0/19", vld_o, result);
        end
        step(16'd4, 16'd4, 2'b01);
        step(16'hFFFF, 16'd3, 2'b00);
        idle();
        checks++;
        if (vld_o !== 1'b0 || result !== 32'd13) begin
            errors++;
            $display("FAIL bubble_hold: vld_o=%b result=%0d want 0/13", vld_o, result);
        end
        step(16'd2, 16'd5, 2'b00);
        step(16'd1, 16'd1, 2'b10);
        checks++;
        if (vld_o !== 1'b1 || result !== 32'd24) begin
            errors++;
            $display("FAIL bubble_sum: vld_o=%b result=%0d want 1/24", vld_o, result);
        end
    endtask

    initial begin
        test_reset();
        test_ones_128();
        test_signed();
        test_back_to_back();
        test_single_wrap();
        test_restart();
        test_reset_mid_vector();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
